// File: rtl/iiitb_pwm_duty_ctrl.sv
// Duty-step sequencer for iiitb_pwm_gen: turns a target step into
// timed increase/decrease presses while tracking the generator's step.
module iiitb_pwm_duty_ctrl #(
    parameter int STEP_W      = 4,
    parameter int MAX_STEP    = 10,
    parameter int INIT_STEP   = 5,
    parameter int HOLD_CYCLES = 10,
    parameter int GAP_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STEP_W-1:0] target_step,
    input  logic              target_valid,
    output logic              target_ready,
    output logic              increase_duty,
    output logic              decrease_duty,
    output logic [STEP_W-1:0] cur_step,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [STEP_W-1:0] MAX_S     = STEP_W'(MAX_STEP);
    localparam logic [STEP_W-1:0] INIT_S    = STEP_W'(INIT_STEP);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] tgt_q, tgt_d;
    logic [STEP_W-1:0] cur_q, cur_d;
    logic              inc_q, inc_d;
    logic              dec_q, dec_d;
    logic              done_q, done_d;
    logic [STEP_W-1:0] req_step;

    always_comb begin
        req_step = (target_step > MAX_S) ? MAX_S : target_step;
        state_d  = state_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        cur_d    = cur_q;
        inc_d    = inc_q;
        dec_d    = dec_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (target_valid) begin
                    tgt_d = req_step;
                    if (req_step == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = PRESS;
                        cnt_d   = '0;
                        inc_d   = (req_step > cur_q);
                        dec_d   = (req_step < cur_q);
                    end
                end
            end
            PRESS: begin
                if (cnt_q == HOLD_LAST) begin
                    // the generator registers the step on press release
                    inc_d   = 1'b0;
                    dec_d   = 1'b0;
                    cur_d   = inc_q ? (cur_q + 1'b1) : (cur_q - 1'b1);
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (cur_q == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PRESS;
                        inc_d   = (tgt_q > cur_q);
                        dec_d   = (tgt_q < cur_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                inc_d   = 1'b0;
                dec_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= INIT_S;
            cur_q   <= INIT_S;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign target_ready  = (state_q == IDLE);
    assign busy          = ~target_ready;
    assign increase_duty = inc_q;
    assign decrease_duty = dec_q;
    assign cur_step      = cur_q;
    assign done          = done_q;

endmodule

// File: tb/tb_iiitb_pwm_duty_ctrl.sv
// Randomised bench for iiitb_pwm_duty_ctrl against a cycle-position model
// derived from the press/gap timing rules.
module tb_iiitb_pwm_duty_ctrl;

    localparam int STEP_W = 4;
    localparam int MAXS   = 10;
    localparam int INITS  = 5;
    localparam int H      = 10;
    localparam int G      = 10;
    localparam int SEG    = H + G;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [STEP_W-1:0] target_step = '0;
    logic              target_valid = 1'b0;
    logic              target_ready;
    logic              increase_duty;
    logic              decrease_duty;
    logic [STEP_W-1:0] cur_step;
    logic              busy;
    logic              done;

    int n_chk = 0;
    int n_err = 0;
    int model_cur = INITS;

    iiitb_pwm_duty_ctrl #(
        .STEP_W(STEP_W), .MAX_STEP(MAXS), .INIT_STEP(INITS),
        .HOLD_CYCLES(H), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .target_step(target_step), .target_valid(target_valid),
        .target_ready(target_ready),
        .increase_duty(increase_duty), .decrease_duty(decrease_duty),
        .cur_step(cur_step), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int e_inc, input int e_dec, input int e_cur,
                             input int e_done, input int e_rdy);
        check("inc", int'(increase_duty), e_inc);
        check("dec", int'(decrease_duty), e_dec);
        check("cur_step", int'(cur_step), e_cur);
        check("done", int'(done), e_done);
        check("ready", int'(target_ready), e_rdy);
        check("busy", int'(busy), 1 - e_rdy);
    endtask

    // Request a move; noise pulses valid with junk while busy; rst_at>0
    // asserts reset during that cycle after acceptance.
    task automatic run_move(input int req, input bit noise, input int rst_at);
        int tgt, n, dir, last, k, ph, e_cur, press;
        tgt  = (req > MAXS) ? MAXS : req;
        n    = (tgt > model_cur) ? tgt - model_cur : model_cur - tgt;
        dir  = (tgt > model_cur) ? 1 : -1;
        last = n * SEG + 1;
        check("ready_before", int'(target_ready), 1);
        target_step  = STEP_W'(req);
        target_valid = 1'b1;
        step();
        target_valid = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c < last) begin
                k     = (c - 1) / SEG;
                ph    = (c - 1) % SEG;
                press = (ph < H) ? 1 : 0;
                e_cur = model_cur + dir * (k + ((ph >= H) ? 1 : 0));
                check_all(press & (dir > 0 ? 1 : 0), press & (dir < 0 ? 1 : 0),
                          e_cur, 0, 0);
            end else begin
                check_all(0, 0, tgt, 1, 1);
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                check_all(0, 0, INITS, 0, 1);
                model_cur = INITS;
                return;
            end
            if (c < last) begin
                target_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                target_step  = STEP_W'($urandom_range(0, 15));
                step();
                target_valid = 1'b0;
            end
        end
        model_cur = tgt;
        step();
        check_all(0, 0, tgt, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        check_all(0, 0, INITS, 0, 1);
        rst_n = 1'b1;
        step();
        check_all(0, 0, INITS, 0, 1);

        run_move(8, 1'b0, 0);
        run_move(0, 1'b0, 0);
        run_move(15, 1'b0, 0);
        run_move(10, 1'b0, 0);
        run_move(5, 1'b1, 0);
        run_move(9, 1'b0, 5);
        run_move(9, 1'b1, 25);
        run_move(3, 1'b0, 0);
        run_move(3, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            run_move(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 40)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
